lnrv_exu_flush: RTL and testbench
=================================

LNRV_EXU_FLUSH -- requirements
Module: lnrv_exu_flush

Interface
REQ-001 SHALL have parameter: PC_W, 32, width of every PC/operand port.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: excp_flush_req  in  1 / excp_flush_ack  out  1 / excp_flush_pc_op1, excp_flush_pc_op2  in  PC_W: exception/trap flush source.
REQ-005 SHALL have ports: sys_flush_req  in  1 / sys_flush_ack  out  1 / sys_flush_pc_op1, sys_flush_pc_op2  in  PC_W: mret/dret/fence.i flush source.
REQ-006 SHALL have ports: bjp_flush_req  in  1 / bjp_flush_ack  out  1 / bjp_flush_pc_op1, bjp_flush_pc_op2  in  PC_W: branch-mispredict flush source.
REQ-007 SHALL have ports: pipe_flush  out  1  kill of all younger instructions in ifu/idu/exu.
REQ-008 SHALL have ports: ifu_redirect_vld  out  1 / ifu_redirect_rdy  in  1 / ifu_redirect_pc  out  PC_W: fetch redirect handshake.
REQ-009 SHALL have ports: flush_busy  out  1  high while state is not IDLE.

Function
REQ-010 SHALL implement FSM with states IDLE and REDIRECT only.
REQ-011 In IDLE, SHALL grant exactly one requesting source by fixed priority excp > sys > bjp.
REQ-012 Ack SHALL be combinational: granted source's ack = its req & (state==IDLE); all other acks 0; acks SHALL be 0 in REDIRECT.
REQ-013 pipe_flush SHALL equal OR of the three acks (same cycle as acceptance, combinational).
REQ-014 On acceptance edge SHALL register target = (op1 + op2) mod 2^PC_W of granted source, bit 0 forced to 0, and move to REDIRECT.
REQ-015 In REDIRECT SHALL drive ifu_redirect_vld=1 and ifu_redirect_pc=target, stable until ifu_redirect_rdy sampled high.
REQ-016 On vld & rdy edge SHALL return to IDLE; no acceptance in that same cycle.
REQ-017 Latency: req accepted cycle N -> vld first high cycle N+1 -> earliest next acceptance cycle N+2.
REQ-018 Requests present during REDIRECT SHALL be ignored (no ack, no state change); sources hold or drop them on pipe_flush.
REQ-019 Simultaneous requests SHALL ack only the winner; losers stay unacked and are re-arbitrated next IDLE cycle.
REQ-020 Operand sum overflow SHALL wrap silently (e.g. 0xFFFF_FFFE + 4 -> 0x0000_0002).
REQ-021 ifu_redirect_pc SHALL be 0 whenever ifu_redirect_vld is 0.

Reset
REQ-022 While reset=1 at an edge: state<=IDLE, target<=0; next cycle ifu_redirect_vld=0, flush_busy=0, all acks=0 regardless of reqs during reset.
REQ-023 Reset asserted in REDIRECT SHALL abandon the pending redirect; no redirect handshake after reset release unless a new request is accepted.
REQ-024 pipe_flush SHALL be 0 in any cycle where reset=1.

Structure
REQ-025 FSM state encodings, source-index encoding and PC_W default SHALL live in the shared lnrv defines header.
REQ-026 Fixed-priority grant logic SHALL be one sub-module lnrv_exu_flush_arb (3 req in, one-hot grant out, purely combinational); FSM and target register stay in the top.

Verification
REQ-027 excp req op1=0x8000_0100 op2=0, rdy=1 -> excp_ack & pipe_flush cycle 0, vld with pc 0x8000_0100 cycle 1, IDLE cycle 2.
REQ-028 excp, sys, bjp all requesting same cycle -> only excp_ack=1; sys_ack at next IDLE cycle if still requesting.
REQ-029 bjp req op1=0x0000_1000 op2=0x0000_0011, rdy=0 for 5 cycles -> vld held 5+ cycles, pc 0x0000_1010, no ack to new sys req until handshake done.
REQ-030 op1=0xFFFF_FFFE op2=4 -> ifu_redirect_pc=0x0000_0002.
REQ-031 reset=1 asserted while in REDIRECT with rdy=0 -> vld=0, flush_busy=0 the cycle after; no further vld without new req.

Source files
------------

// File: rtl/lnrv_exu_flush_pkg.sv
// Shared definitions for the execute-stage flush controller.
// Holds the default PC width, FSM state encoding and flush-source indices.
// Imported by the arbiter and the top so encodings stay consistent.
package lnrv_exu_flush_pkg;

    // Default width of every PC / operand port.
    localparam int LNRV_PC_W = 32;

    // Flush controller states: idle (accepting) or redirecting fetch.
    typedef enum logic {
        FLUSH_IDLE     = 1'b0,
        FLUSH_REDIRECT = 1'b1
    } flush_state_e;

    // Flush source indices; lower index wins arbitration.
    localparam int SRC_N    = 3;
    localparam int SRC_EXCP = 0;
    localparam int SRC_SYS  = 1;
    localparam int SRC_BJP  = 2;

endpackage

// File: rtl/lnrv_exu_flush_arb.sv
// Fixed-priority flush source arbiter: excp > sys > bjp, one-hot grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the top qualifies the grant with its idle state.
module lnrv_exu_flush_arb
    import lnrv_exu_flush_pkg::*;
(
    input  logic [SRC_N-1:0] req,
    output logic [SRC_N-1:0] gnt
);

    // Highest-priority requester wins; at most one grant bit set.
    always_comb begin
        gnt = '0;
        if (req[SRC_EXCP]) begin
            gnt[SRC_EXCP] = 1'b1;
        end else if (req[SRC_SYS]) begin
            gnt[SRC_SYS] = 1'b1;
        end else if (req[SRC_BJP]) begin
            gnt[SRC_BJP] = 1'b1;
        end
    end

endmodule

// File: rtl/lnrv_exu_flush.sv
// Pipeline flush controller: arbitrates flush sources, kills younger instructions, redirects fetch.
// Latency: accept in cycle N (combinational ack/pipe_flush), redirect valid from N+1, next accept at N+2 earliest.
// Backpressure: holds redirect valid/pc until ifu_redirect_rdy; requests are not acked while redirecting.
module lnrv_exu_flush
    import lnrv_exu_flush_pkg::*;
#(
    parameter int PC_W = LNRV_PC_W
)
(
    input  logic            clk,
    input  logic            reset,

    input  logic            excp_flush_req,
    output logic            excp_flush_ack,
    input  logic [PC_W-1:0] excp_flush_pc_op1,
    input  logic [PC_W-1:0] excp_flush_pc_op2,

    input  logic            sys_flush_req,
    output logic            sys_flush_ack,
    input  logic [PC_W-1:0] sys_flush_pc_op1,
    input  logic [PC_W-1:0] sys_flush_pc_op2,

    input  logic            bjp_flush_req,
    output logic            bjp_flush_ack,
    input  logic [PC_W-1:0] bjp_flush_pc_op1,
    input  logic [PC_W-1:0] bjp_flush_pc_op2,

    output logic            pipe_flush,

    output logic            ifu_redirect_vld,
    input  logic            ifu_redirect_rdy,
    output logic [PC_W-1:0] ifu_redirect_pc,

    output logic            flush_busy
);

    flush_state_e     state;
    flush_state_e     state_nxt;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  target_sum;
    logic [PC_W-1:0]  target_nxt;
    logic [SRC_N-1:0] req_vec;
    logic [SRC_N-1:0] gnt_vec;
    logic [SRC_N-1:0] ack_vec;
    logic             accept_en;
    logic             accept;

    assign req_vec[SRC_EXCP] = excp_flush_req;
    assign req_vec[SRC_SYS]  = sys_flush_req;
    assign req_vec[SRC_BJP]  = bjp_flush_req;

    lnrv_exu_flush_arb u_arb (
        .req (req_vec),
        .gnt (gnt_vec)
    );

    // Acceptance only in IDLE and never while reset is asserted, so
    // pipe_flush cannot fire during reset even if state is stale.
    assign accept_en = (state == FLUSH_IDLE) && !reset;
    assign ack_vec   = gnt_vec & req_vec & {SRC_N{accept_en}};
    assign accept    = |ack_vec;

    assign excp_flush_ack = ack_vec[SRC_EXCP];
    assign sys_flush_ack  = ack_vec[SRC_SYS];
    assign bjp_flush_ack  = ack_vec[SRC_BJP];
    assign pipe_flush     = accept;

    // Select the granted source's operands and form the wrapped sum.
    always_comb begin
        target_sum = '0;
        if (gnt_vec[SRC_EXCP]) begin
            target_sum = excp_flush_pc_op1 + excp_flush_pc_op2;
        end else if (gnt_vec[SRC_SYS]) begin
            target_sum = sys_flush_pc_op1 + sys_flush_pc_op2;
        end else if (gnt_vec[SRC_BJP]) begin
            target_sum = bjp_flush_pc_op1 + bjp_flush_pc_op2;
        end
    end

    // Fetch targets are at least halfword aligned; bit 0 is always cleared.
    assign target_nxt = {target_sum[PC_W-1:1], 1'b0};

    // Next-state: IDLE -> REDIRECT on accept; REDIRECT -> IDLE on handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FLUSH_IDLE: begin
                if (accept) begin
                    state_nxt = FLUSH_REDIRECT;
                end
            end
            FLUSH_REDIRECT: begin
                if (ifu_redirect_rdy) begin
                    state_nxt = FLUSH_IDLE;
                end
            end
            default: state_nxt = FLUSH_IDLE;
        endcase
    end

    // State and target registers; reset abandons any pending redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FLUSH_IDLE;
            target <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                target <= target_nxt;
            end
        end
    end

    assign ifu_redirect_vld = (state == FLUSH_REDIRECT);
    assign ifu_redirect_pc  = ifu_redirect_vld ? target : '0;
    assign flush_busy       = (state != FLUSH_IDLE);

endmodule

// File: tb/tb_lnrv_exu_flush.sv
module tb_lnrv_exu_flush;

    localparam int PC_W = 32;

    logic            clk;
    logic            reset;
    logic            excp_flush_req;
    logic            excp_flush_ack;
    logic [PC_W-1:0] excp_flush_pc_op1;
    logic [PC_W-1:0] excp_flush_pc_op2;
    logic            sys_flush_req;
    logic            sys_flush_ack;
    logic [PC_W-1:0] sys_flush_pc_op1;
    logic [PC_W-1:0] sys_flush_pc_op2;
    logic            bjp_flush_req;
    logic            bjp_flush_ack;
    logic [PC_W-1:0] bjp_flush_pc_op1;
    logic [PC_W-1:0] bjp_flush_pc_op2;
    logic            pipe_flush;
    logic            ifu_redirect_vld;
    logic            ifu_redirect_rdy;
    logic [PC_W-1:0] ifu_redirect_pc;
    logic            flush_busy;

    int              n_checks;
    int              n_fail;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] mon_exp;

    lnrv_exu_flush #(.PC_W(PC_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .excp_flush_req    (excp_flush_req),
        .excp_flush_ack    (excp_flush_ack),
        .excp_flush_pc_op1 (excp_flush_pc_op1),
        .excp_flush_pc_op2 (excp_flush_pc_op2),
        .sys_flush_req     (sys_flush_req),
        .sys_flush_ack     (sys_flush_ack),
        .sys_flush_pc_op1  (sys_flush_pc_op1),
        .sys_flush_pc_op2  (sys_flush_pc_op2),
        .bjp_flush_req     (bjp_flush_req),
        .bjp_flush_ack     (bjp_flush_ack),
        .bjp_flush_pc_op1  (bjp_flush_pc_op1),
        .bjp_flush_pc_op2  (bjp_flush_pc_op2),
        .pipe_flush        (pipe_flush),
        .ifu_redirect_vld  (ifu_redirect_vld),
        .ifu_redirect_rdy  (ifu_redirect_rdy),
        .ifu_redirect_pc   (ifu_redirect_pc),
        .flush_busy        (flush_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every completed redirect handshake must match the oldest expected target.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifu_redirect_vld === 1'b1 && ifu_redirect_rdy === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL redirect_unexpected: handshake with pc %h, none expected", ifu_redirect_pc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (ifu_redirect_pc !== mon_exp) begin
                        n_fail++;
                        $display("FAIL redirect_pc: got %h, expected %h", ifu_redirect_pc, mon_exp);
                    end
                end
            end
            if (ifu_redirect_vld === 1'b0) begin
                n_checks++;
                if (ifu_redirect_pc !== '0) begin
                    n_fail++;
                    $display("FAIL pc_zero_when_idle: got %h, expected 0", ifu_redirect_pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        excp_flush_req = 1'b1; sys_flush_req = 1'b1; bjp_flush_req = 1'b1;
        excp_flush_pc_op1 = 32'h10; excp_flush_pc_op2 = 32'h4;
        sys_flush_pc_op1 = 32'h20;  sys_flush_pc_op2 = 32'h4;
        bjp_flush_pc_op1 = 32'h30;  bjp_flush_pc_op2 = 32'h4;
        ifu_redirect_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pipe_flush !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_flush_pre: got %b, expected 0", pipe_flush); end
        tick();
        @(negedge clk);
        n_checks++;
        if (pipe_flush !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_flush: got %b, expected 0", pipe_flush); end
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack} !== 3'b000) begin
            n_fail++; $display("FAIL reset_acks: got %b, expected 000", {excp_flush_ack, sys_flush_ack, bjp_flush_ack});
        end
        n_checks++;
        if (ifu_redirect_vld !== 1'b0 || flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld_busy: got vld=%b busy=%b, expected 0 0", ifu_redirect_vld, flush_busy);
        end
        n_checks++;
        if (ifu_redirect_pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", ifu_redirect_pc); end
        tick();
        reset = 1'b0;
        excp_flush_req = 1'b0; sys_flush_req = 1'b0; bjp_flush_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b0 || flush_busy !== 1'b0 || pipe_flush !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got vld=%b busy=%b flush=%b, expected 0 0 0", ifu_redirect_vld, flush_busy, pipe_flush);
        end
    endtask

    task automatic test_basic();
        tick();
        excp_flush_req = 1'b1; excp_flush_pc_op1 = 32'h8000_0100; excp_flush_pc_op2 = 32'h0;
        ifu_redirect_rdy = 1'b1;
        exp_q.push_back(32'h8000_0100);
        @(negedge clk);
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack, pipe_flush} !== 4'b1001) begin
            n_fail++; $display("FAIL basic_ack: got e/s/b/flush=%b, expected 1001", {excp_flush_ack, sys_flush_ack, bjp_flush_ack, pipe_flush});
        end
        n_checks++;
        if (ifu_redirect_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_c0: got %b, expected 0", ifu_redirect_vld); end
        tick();
        excp_flush_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b1 || ifu_redirect_pc !== 32'h8000_0100 || flush_busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_redirect: got vld=%b pc=%h busy=%b, expected 1 80000100 1", ifu_redirect_vld, ifu_redirect_pc, flush_busy);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b0 || flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_back_idle: got vld=%b busy=%b, expected 0 0", ifu_redirect_vld, flush_busy);
        end
    endtask

    task automatic test_priority();
        tick();
        excp_flush_req = 1'b1; excp_flush_pc_op1 = 32'h100; excp_flush_pc_op2 = 32'h0;
        sys_flush_req  = 1'b1; sys_flush_pc_op1  = 32'h200; sys_flush_pc_op2  = 32'h4;
        bjp_flush_req  = 1'b1; bjp_flush_pc_op1  = 32'h300; bjp_flush_pc_op2  = 32'h8;
        ifu_redirect_rdy = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h308);
        @(negedge clk);
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack} !== 3'b100) begin
            n_fail++; $display("FAIL prio_excp_wins: got e/s/b=%b, expected 100", {excp_flush_ack, sys_flush_ack, bjp_flush_ack});
        end
        tick();
        excp_flush_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack, pipe_flush} !== 4'b0000) begin
            n_fail++; $display("FAIL prio_ignored_in_redirect: got e/s/b/flush=%b, expected 0000", {excp_flush_ack, sys_flush_ack, bjp_flush_ack, pipe_flush});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack} !== 3'b010) begin
            n_fail++; $display("FAIL prio_sys_next: got e/s/b=%b, expected 010", {excp_flush_ack, sys_flush_ack, bjp_flush_ack});
        end
        tick();
        sys_flush_req = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if ({excp_flush_ack, sys_flush_ack, bjp_flush_ack} !== 3'b001) begin
            n_fail++; $display("FAIL prio_bjp_last: got e/s/b=%b, expected 001", {excp_flush_ack, sys_flush_ack, bjp_flush_ack});
        end
        tick();
        bjp_flush_req = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_checks++;
        if (flush_busy !== 1'b0) begin n_fail++; $display("FAIL prio_done_idle: got busy=%b, expected 0", flush_busy); end
    endtask

    task automatic test_backpressure();
        tick();
        bjp_flush_req = 1'b1; bjp_flush_pc_op1 = 32'h0000_1000; bjp_flush_pc_op2 = 32'h0000_0011;
        ifu_redirect_rdy = 1'b0;
        exp_q.push_back(32'h0000_1010);
        @(negedge clk);
        n_checks++;
        if (bjp_flush_ack !== 1'b1) begin n_fail++; $display("FAIL bp_bjp_ack: got %b, expected 1", bjp_flush_ack); end
        tick();
        bjp_flush_req = 1'b0;
        sys_flush_req = 1'b1; sys_flush_pc_op1 = 32'h0000_4000; sys_flush_pc_op2 = 32'h0;
        exp_q.push_back(32'h0000_4000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ifu_redirect_vld !== 1'b1 || ifu_redirect_pc !== 32'h0000_1010 || sys_flush_ack !== 1'b0 || pipe_flush !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got vld=%b pc=%h sys_ack=%b flush=%b, expected 1 00001010 0 0",
                                   i, ifu_redirect_vld, ifu_redirect_pc, sys_flush_ack, pipe_flush);
            end
            tick();
        end
        ifu_redirect_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b1 || sys_flush_ack !== 1'b0) begin
            n_fail++; $display("FAIL bp_handshake_cycle: got vld=%b sys_ack=%b, expected 1 0", ifu_redirect_vld, sys_flush_ack);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (sys_flush_ack !== 1'b1) begin n_fail++; $display("FAIL bp_sys_after: got %b, expected 1", sys_flush_ack); end
        tick();
        sys_flush_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_back_to_back();
        tick();
        excp_flush_req = 1'b1; excp_flush_pc_op1 = 32'h2000; excp_flush_pc_op2 = 32'h0;
        ifu_redirect_rdy = 1'b1;
        exp_q.push_back(32'h2000);
        @(negedge clk);
        n_checks++;
        if (excp_flush_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack: got %b, expected 1", excp_flush_ack); end
        tick();
        excp_flush_pc_op1 = 32'h3000; excp_flush_pc_op2 = 32'h2;
        exp_q.push_back(32'h3002);
        @(negedge clk);
        n_checks++;
        if (excp_flush_ack !== 1'b0 || ifu_redirect_vld !== 1'b1) begin
            n_fail++; $display("FAIL b2b_n1: got ack=%b vld=%b, expected 0 1", excp_flush_ack, ifu_redirect_vld);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (excp_flush_ack !== 1'b1 || ifu_redirect_vld !== 1'b0) begin
            n_fail++; $display("FAIL b2b_n2: got ack=%b vld=%b, expected 1 0", excp_flush_ack, ifu_redirect_vld);
        end
        tick();
        excp_flush_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] op1_t[3];
        logic [PC_W-1:0] op2_t[3];
        logic [PC_W-1:0] exp_t[3];
        op1_t[0] = 32'hFFFF_FFFE; op2_t[0] = 32'h4;         exp_t[0] = 32'h0000_0002;
        op1_t[1] = 32'h1234_5677; op2_t[1] = 32'h10;        exp_t[1] = 32'h1234_5686;
        op1_t[2] = 32'hFFFF_FFFF; op2_t[2] = 32'hFFFF_FFFF; exp_t[2] = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            tick();
            excp_flush_req = 1'b1; excp_flush_pc_op1 = op1_t[i]; excp_flush_pc_op2 = op2_t[i];
            ifu_redirect_rdy = 1'b1;
            exp_q.push_back(exp_t[i]);
            @(negedge clk);
            tick();
            excp_flush_req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (ifu_redirect_pc !== exp_t[i]) begin
                n_fail++; $display("FAIL wrap[%0d]: got pc %h, expected %h", i, ifu_redirect_pc, exp_t[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_in_redirect();
        tick();
        excp_flush_req = 1'b1; excp_flush_pc_op1 = 32'h5000; excp_flush_pc_op2 = 32'h0;
        ifu_redirect_rdy = 1'b0;
        @(negedge clk);
        tick();
        excp_flush_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b1) begin n_fail++; $display("FAIL rir_vld_before: got %b, expected 1", ifu_redirect_vld); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pipe_flush !== 1'b0) begin n_fail++; $display("FAIL rir_flush_in_reset: got %b, expected 0", pipe_flush); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifu_redirect_vld !== 1'b0 || flush_busy !== 1'b0) begin
            n_fail++; $display("FAIL rir_abandon: got vld=%b busy=%b, expected 0 0", ifu_redirect_vld, flush_busy);
        end
        ifu_redirect_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if (ifu_redirect_vld !== 1'b0) begin
                n_fail++; $display("FAIL rir_no_vld[%0d]: got %b, expected 0", i, ifu_redirect_vld);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        excp_flush_req = 1'b0; sys_flush_req = 1'b0; bjp_flush_req = 1'b0;
        excp_flush_pc_op1 = '0; excp_flush_pc_op2 = '0;
        sys_flush_pc_op1 = '0;  sys_flush_pc_op2 = '0;
        bjp_flush_pc_op1 = '0;  bjp_flush_pc_op2 = '0;
        ifu_redirect_rdy = 1'b0;

        test_reset();
        test_basic();
        test_priority();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_in_redirect();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending redirects, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
